// File: rtl/ascon_ti_share_gen.sv
// Masking front-end for the 3-share TI Ascon datapath: splits five unmasked state
// words into Boolean shares. Optional debug bypass of the masks via ASCON_TI_BYPASS_EN.
module ascon_ti_share_gen #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned NUM_WORDS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W-1:0]             in_word,
  input  logic                          rnd_valid,
  output logic                          rnd_ready,
  input  logic [2*WORD_W-1:0]           rnd_data,
`ifdef ASCON_TI_BYPASS_EN
  input  logic                          mask_bypass,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W*NUM_WORDS-1:0]   out_sh0,
  output logic [WORD_W*NUM_WORDS-1:0]   out_sh1,
  output logic [WORD_W*NUM_WORDS-1:0]   out_sh2,
  output logic [2:0]                    word_cnt
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned STATE_W = WORD_W * NUM_WORDS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    OUT     = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                valid_d;
  logic [STATE_W-1:0]  sh0_d, sh1_d, sh2_d;
  logic                collect;
  logic                bypass;
  logic                fire;
  logic [WORD_W-1:0]   r0, r1;

`ifdef ASCON_TI_BYPASS_EN
  assign bypass = mask_bypass;
`else
  assign bypass = 1'b0;
`endif

  // Handshake: word and randomness are consumed together; neither ready looks at its own valid
  assign collect   = (state == COLLECT);
  assign in_ready  = collect & (rnd_valid | bypass);
  assign rnd_ready = collect & in_valid & ~bypass;
  assign fire      = collect & in_valid & (rnd_valid | bypass);

  assign r0 = bypass ? '0 : rnd_data[WORD_W-1:0];
  assign r1 = bypass ? '0 : rnd_data[2*WORD_W-1:WORD_W];

  // State and share registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      out_sh0   <= '0;
      out_sh1   <= '0;
      out_sh2   <= '0;
    end else begin
      state     <= state_d;
      word_cnt  <= cnt_d;
      out_valid <= valid_d;
      out_sh0   <= sh0_d;
      out_sh1   <= sh1_d;
      out_sh2   <= sh2_d;
    end
  end

  // Next-state: share the selected word on fire, hand off once all words are in
  always_comb begin
    state_d = state;
    cnt_d   = word_cnt;
    valid_d = out_valid;
    sh0_d   = out_sh0;
    sh1_d   = out_sh1;
    sh2_d   = out_sh2;
    case (state)
      COLLECT: begin
        if (fire) begin
          for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (word_cnt == CNT_W'(k)) begin
              sh0_d[k*WORD_W +: WORD_W] = r0;
              sh1_d[k*WORD_W +: WORD_W] = r1;
              sh2_d[k*WORD_W +: WORD_W] = in_word ^ r0 ^ r1;
            end
          end
          cnt_d = word_cnt + CNT_W'(1);
          if (word_cnt == LAST_IDX) begin
            state_d = OUT;
            valid_d = 1'b1;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = COLLECT;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/ascon_ti_share_gen.md
Name: ascon_ti_share_gen

Overview:
- Masking front-end for the 3-share threshold-implementation Ascon permutation datapath.
- Accepts the unmasked Ascon state as five sequential 64-bit words x0..x4, plus fresh randomness from a PRNG.
- Splits each word into 3 Boolean shares and assembles a full 320-bit state per share.
- Presents the three shared states to the TI round logic with a valid/ready handshake. It is the producer of the shares the TI substitution layer consumes.

Parameters:
- WORD_W, 64, width of one Ascon state word.
- NUM_WORDS, 5, number of state words per shared state. The counter width is 3 bits, fixed for the default.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_word  in  WORD_W  unmasked state word; k-th accepted word is xk.
- rnd_valid  in  1  randomness valid.
- rnd_ready  out  1  randomness consumed when rnd_valid & rnd_ready.
- rnd_data  in  2*WORD_W  masks; r0 = rnd_data[63:0], r1 = rnd_data[127:64].
- out_valid  out  1  shared state valid.
- out_ready  in  1  downstream accepts shared state.
- out_sh0  out  WORD_W*NUM_WORDS  share 0 of state; word k at bits [64k+63:64k].
- out_sh1  out  WORD_W*NUM_WORDS  share 1.
- out_sh2  out  WORD_W*NUM_WORDS  share 2.
- word_cnt  out  3  number of words collected in current state (0..5).

Behaviour:
- FSM states are COLLECT and OUT. Reset state is COLLECT.
- Reset values: word_cnt=0, out_valid=0, out_sh0/1/2 all zero.
- in_ready = (state==COLLECT) & rnd_valid.
- rnd_ready = (state==COLLECT) & in_valid.
- Neither ready depends on its own valid, so there is no combinational loop.
- fire = in_valid & rnd_valid & (state==COLLECT). On fire, the word and its randomness are consumed together in the same cycle. No word is ever masked with stale or reused randomness.
- On fire with k=word_cnt:
  - sh0 word k <= r0
  - sh1 word k <= r1
  - sh2 word k <= in_word ^ r0 ^ r1
  - word_cnt <= k+1.
- Recombination invariant: sh0^sh1^sh2 == x for every word.
- When fire occurs with word_cnt==4, the next state is OUT, word_cnt=5 and out_valid=1, registered. Latency from the 5th fire to out_valid is 1 cycle.
- In OUT:
  - in_ready=0 and rnd_ready=0.
  - out_sh* are held stable while out_valid & !out_ready.
- On out_valid & out_ready:
  - next state is COLLECT, word_cnt=0, out_valid=0.
  - Share registers keep their contents (not cleared) until overwritten word-by-word.
  - One bubble cycle: a new word cannot be accepted in the same cycle as the output handshake.
- in_valid with rnd_valid=0: stall, no state change. The word must be held by the source (standard valid/ready).
- rnd_valid with in_valid=0: randomness is not consumed.
- No reuse of r0/r1 across words. Each fire consumes exactly one rnd_data beat.
- rst_n low mid-collection or in OUT: the partial state is discarded. All registers return to their reset values at the next clock edge. out_valid drops even if out_ready was low.
- Unmasked data is never stored in a single register. Only shares are registered.

Optional Feature:
- Macro ASCON_TI_BYPASS_EN.
- When defined:
  - Adds input port mask_bypass (1 bit), sampled per fire.
  - While mask_bypass=1: in_ready = (state==COLLECT); rnd_ready=0; fire = in_valid & (state==COLLECT); r0 and r1 are treated as zero, so sh0=sh1=0 and sh2=in_word.
  - For debug and known-answer testing only.
- When undefined:
  - Port absent.
  - Behaviour exactly as above; randomness is always required.

Test Plan:
- Reset, then 5 words x0..x4 = 64'h0123456789ABCDEF + k, each with r0=64'hAAAA..AA and r1=64'h5555..55, out_ready=1:
  - out_valid rises one cycle after the 5th fire.
  - out_sh0 words all AA..AA; out_sh1 words all 55..55.
  - out_sh2 word k = xk ^ 64'hFFFF_FFFF_FFFF_FFFF.
  - sh0^sh1^sh2 == x for every word.
- in_valid held high while rnd_valid toggles 1,0,0,1,1,0,1,1: only fires on rnd_valid=1 cycles are counted. word_cnt increments exactly 5 times; rnd_ready is never high with in_ready low in OUT.
- Full state collected, out_ready held 0 for 10 cycles: out_valid stays 1 and out_sh* are unchanged. in_ready=0 and rnd_ready=0 throughout. Raising out_ready produces one handshake, after which word_cnt=0 next cycle.
- Back-to-back states with all valids/out_ready tied high: exactly 6 cycles per state (5 fires + 1 output/bubble). Two consecutive states decode to the correct x values.
- Assert rst_n=0 for one cycle after 3 fires: word_cnt=0, out_valid=0, out_sh*=0. Then 5 new words produce a correct state with no residue from the aborted one.
- With ASCON_TI_BYPASS_EN defined, mask_bypass=1, rnd_valid=0, x0..x4 = 64'h1..64'h5: state completes, rnd_ready stays 0, out_sh0=out_sh1=0, out_sh2 words = 1..5.
